// File: rtl/uart_rx.sv
// 8N1 UART receiver: deframes bytes from rx and emits each one as a one-cycle data_en strobe.
// Optional macro UART_RX_SYNC_EN adds a two-flop synchronizer on rx for asynchronous pins.
module uart_rx #(
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned MAIN_CLK = 12000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_en,
  output logic       frame_err
);

  localparam int unsigned N       = MAIN_CLK / BAUD;
  localparam int unsigned HALF    = (N - 1) / 2;
  localparam int unsigned CW      = $clog2(N + 1);
  localparam int unsigned HALF_M1 = (HALF > 0) ? HALF - 1 : 0;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  logic          rx_s;
  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    idx, idx_d;
  logic [7:0]    shift, shift_d;
  logic [7:0]    data_out_d;
  logic          data_en_d, frame_err_d;

`ifdef UART_RX_SYNC_EN
  // Both stages reset to the idle line level so reset never fakes a start bit.
  logic [1:0] sync;
  always_ff @(posedge clk) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], rx};
  end
  assign rx_s = sync[1];
`else
  assign rx_s = rx;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      data_out  <= '0;
      data_en   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      idx       <= idx_d;
      shift     <= shift_d;
      data_out  <= data_out_d;
      data_en   <= data_en_d;
      frame_err <= frame_err_d;
    end
  end

  // Each sample point is reached when cnt hits zero; cnt reloads to N-1 on every sample.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    idx_d       = idx;
    shift_d     = shift;
    data_out_d  = data_out;
    data_en_d   = 1'b0;
    frame_err_d = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          idx_d = '0;
          if (HALF == 0) begin
            state_d = DATA;
            cnt_d   = CW'(N - 1);
          end else begin
            state_d = START;
            cnt_d   = CW'(HALF_M1);
          end
        end
      end
      START: begin
        if (cnt == '0) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            cnt_d   = CW'(N - 1);
          end
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          shift_d[idx] = rx_s;
          cnt_d        = CW'(N - 1);
          idx_d        = idx + 1'b1;
          if (idx == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      STOP: begin
        if (cnt == '0) begin
          if (rx_s) begin
            data_out_d = shift;
            data_en_d  = 1'b1;
            state_d    = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      BREAK: begin
        // A line held low must return high before another start is accepted.
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
